// File: rtl/hc4_rom_loader.sv
// hc4_rom_loader: streams a framed byte image into the hc4 core's 4096x8 instruction ROM
//
// Frame: 0xA5, len_hi (upper nibble must be 0), len_lo, len+1 data bytes
//        [, checksum byte when HC4_LOADER_CHECKSUM_EN is defined]
//
// Ports:
//   clk          system clock, all state updates on posedge
//   nReset       asynchronous active-low reset
//   rx_valid     upstream byte strobe
//   rx_data      upstream byte
//   rx_ready     loader can accept a byte (low only in a ROM write cycle)
//   rom_we       one-cycle ROM write strobe
//   rom_addr     ROM write address
//   rom_wdata    ROM write data
//   core_nReset  registered active-low core reset, high only after a good load
//   busy         header/data/checksum in progress
//   error        malformed header or checksum mismatch
//
// Config macro: HC4_LOADER_CHECKSUM_EN adds the CSUM state and a mod-256 sum.
module hc4_rom_loader (
    input  logic        clk,
    input  logic        nReset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        rom_we,
    output logic [11:0] rom_addr,
    output logic [7:0]  rom_wdata,
    output logic        core_nReset,
    output logic        busy,
    output logic        error
);
`ifdef HC4_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, DONE, ERR} state_t;
`endif
    state_t      state_q, state_d;
    logic [11:0] len_q, len_d, cnt_q, cnt_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d, core_q, core_d;
    logic        acc;
`ifdef HC4_LOADER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

    // No byte is taken during a write cycle, which caps throughput at one byte per two cycles.
    assign acc = rx_valid & ~we_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
`ifdef HC4_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            IDLE: state_d = (acc && rx_data == 8'hA5) ? LEN_HI : IDLE;
            LEN_HI: if (acc) begin
                len_d[11:8] = rx_data[3:0];
                state_d     = (rx_data[7:4] != 4'h0) ? ERR : LEN_LO;
            end
            LEN_LO: if (acc) begin
                len_d[7:0] = rx_data;
                cnt_d      = 12'h000;
`ifdef HC4_LOADER_CHECKSUM_EN
                sum_d      = 8'h00;
`endif
                state_d    = DATA;
            end
            DATA: if (we_q) begin
                // Hold the counter at len on the last write so it never wraps.
                if (cnt_q == len_q) begin
`ifdef HC4_LOADER_CHECKSUM_EN
                    state_d = CSUM;
`else
                    state_d = DONE;
`endif
                end else begin
                    cnt_d = cnt_q + 12'h001;
                end
            end else if (acc) begin
                wdata_d = rx_data;
                we_d    = 1'b1;
`ifdef HC4_LOADER_CHECKSUM_EN
                sum_d   = sum_q + rx_data;
`endif
            end
`ifdef HC4_LOADER_CHECKSUM_EN
            CSUM: if (acc) state_d = (rx_data == sum_q) ? DONE : ERR;
`endif
            DONE, ERR: if (acc && rx_data == 8'hA5) state_d = LEN_HI;
            default: state_d = IDLE;
        endcase
        // Registered from next state so the core reset is glitch-free and drops the cycle after a reload A5.
        core_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            len_q   <= 12'h000;
            cnt_q   <= 12'h000;
            wdata_q <= 8'h00;
            we_q    <= 1'b0;
            core_q  <= 1'b0;
`ifdef HC4_LOADER_CHECKSUM_EN
            sum_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            core_q  <= core_d;
`ifdef HC4_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign rx_ready    = ~we_q;
    assign rom_we      = we_q;
    assign rom_addr    = cnt_q;
    assign rom_wdata   = wdata_q;
    assign core_nReset = core_q;
`ifdef HC4_LOADER_CHECKSUM_EN
    assign busy        = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA) || (state_q == CSUM);
`else
    assign busy        = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA);
`endif
    assign error       = (state_q == ERR);
endmodule

// File: doc/hc4_rom_loader.md
HC4_ROM_LOADER -- requirements
Module: hc4_rom_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. Ports are named clk and nReset as elsewhere in the codebase.
REQ-002 clk  input  1  system clock, all state updates on posedge.
REQ-003 nReset  input  1  asynchronous active-low reset.
REQ-004 rx_valid  input  1  upstream byte strobe.
REQ-005 rx_data  input  8  upstream byte.
REQ-006 rx_ready  output  1  loader can accept a byte; a transfer occurs when rx_valid and rx_ready are both high at posedge clk.
REQ-007 rom_we  output  1  one-cycle write strobe to the core's 4096x8 instruction ROM.
REQ-008 rom_addr  output  12  ROM write address.
REQ-009 rom_wdata  output  8  ROM write data.
REQ-010 core_nReset  output  1  active-low reset driven to the hc4 core; high only when an image has loaded successfully.
REQ-011 busy  output  1  high in the LEN_HI, LEN_LO, DATA and CSUM states.
REQ-012 error  output  1  high in the ERR state.

Function
REQ-013 The FSM SHALL have the states IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE and ERR.
REQ-014 IDLE: an accepted byte 0xA5 goes to LEN_HI; any other byte is discarded and the FSM stays in IDLE.
REQ-015 LEN_HI: rx_data[3:0] is captured into len[11:8]; a nonzero rx_data[7:4] goes to ERR; otherwise the FSM goes to LEN_LO.
REQ-016 LEN_LO: rx_data is captured into len[7:0]; the address counter is cleared to 0; the FSM goes to DATA. len encodes the byte count minus 1, so 0x000 means 1 byte and 0xFFF means 4096 bytes.
REQ-017 DATA: each accepted byte is registered.
- In the following cycle rom_we=1, rom_addr=counter and rom_wdata=byte.
- The counter increments after that write.
- Write latency is exactly 1 cycle from acceptance.
REQ-018 rx_ready SHALL be 0 during the rom_we cycle and 1 in every other cycle, in all states. Maximum throughput is 1 data byte per 2 cycles.
REQ-019 When the byte written at rom_addr==len completes, the FSM goes to CSUM (or to DONE, per REQ-026). The counter never wraps past len; the 12-bit address never overflows, including when len=0xFFF.
REQ-020 DONE: core_nReset=1. An accepted 0xA5 goes to LEN_HI and drops core_nReset to 0 in the next cycle (reload); any other byte is ignored.
REQ-021 ERR: core_nReset=0 and error=1. An accepted 0xA5 goes to LEN_HI and clears error; any other byte is ignored.
REQ-022 rom_we SHALL never assert outside the DATA state's write cycles. In particular, no write occurs for header or checksum bytes.

Reset
REQ-023 nReset low SHALL immediately, without waiting for clk, force the following values:
- state=IDLE
- core_nReset=0, rom_we=0, rom_addr=0, rom_wdata=0
- rx_ready=1, busy=0, error=0
- len=0, checksum accumulator=0
REQ-024 nReset asserted mid-load SHALL abort the load with no further rom_we pulses. After release, a full header is required before any further write.
REQ-025 core_nReset SHALL be a register output, glitch-free, and asserted low asynchronously with nReset.

Configuration
REQ-026 Macro HC4_LOADER_CHECKSUM_EN selects whether the checksum is checked.
- Defined: the block keeps an 8-bit modulo-256 sum of all data bytes, cleared in LEN_LO. After the last data byte the FSM enters CSUM; the next accepted byte goes to DONE if it equals the sum, otherwise to ERR.
- Undefined: there is no CSUM state and no accumulator; the FSM goes from DATA directly to DONE after the last write.

Verification
REQ-027 Stream A5 00 02 11 22 33, with checksum disabled, produces:
- writes (0,11), (1,22), (2,33), each one cycle after acceptance
- rx_ready low in each write cycle
- core_nReset rising after the third write
REQ-028 Stream A5 00 01 10 20 30 with checksum enabled produces DONE and core_nReset=1. Stream A5 00 01 10 20 31 produces ERR, error=1, core_nReset=0, and exactly 2 writes.
REQ-029 Stream 00 FF A5 10 produces no writes and ends in ERR, because the upper nibble is nonzero. A following A5 00 00 7E (plus checksum 7E if enabled) writes (0,7E) and reaches DONE.
REQ-030 Stream A5 0F FF followed by 4096 bytes with value address[7:0] produces a final write at (FFF, FF), no wrap, and DONE.
REQ-031 nReset pulsed low after 2 of 3 data bytes gives an immediate return to reset values and no third write. Sending A5 after DONE drops core_nReset low one cycle after acceptance.
